q3_seq_detector: RTL and testbench
==================================

# q3_seq_detector

Downstream consumer of the 3-bit `d_ff` register output. Watches the registered 3-bit `q` stream one sample per enabled clock and detects an ordered three-value sequence (PAT0, PAT1, PAT2). On each detection it emits a registered one-cycle `hit` pulse and increments a saturating hit counter. It sits directly after the 3-bit flip-flop stage in the sequential-circuits datapath.

## Interface
- `W`, 3: sample width; must match the upstream flip-flop width.
- `PAT0`, 3'd1: first value of the sequence.
- `PAT1`, 3'd5: second value.
- `PAT2`, 3'd7: third value.
- `CNT_W`, 8: hit counter width.

- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  reset, synchronous and active-high; the name follows the codebase convention, and 1 resets on the next posedge.
- `en`  in  1  sample qualifier; `q` is consumed only when `en`=1.
- `q`  in  W  registered sample from the upstream flip-flop.
- `hit`  out  1  registered pulse, high for one cycle per detection.
- `hit_cnt`  out  CNT_W  number of detections since reset, saturating.
- `state_o`  out  2  current FSM state, for debug.
- `last_q`  out  W  last sample consumed with `en`=1.

## Operation
- States: IDLE=2'd0, GOT0=2'd1, GOT1=2'd2. Encoding 2'd3 is unused and recovers to IDLE on the next clock.
- Transitions apply only when `en`=1:
  - IDLE: if q==PAT0, go to GOT0; otherwise stay in IDLE.
  - GOT0: if q==PAT1, go to GOT1; else if q==PAT0, stay in GOT0; otherwise go to IDLE.
  - GOT1: if q==PAT2, detection: set `hit`=1, `hit_cnt`+1, next state GOT0 if PAT2==PAT0, else IDLE.
  - GOT1 mismatch: go to GOT0 if q==PAT0, else IDLE.
- Fallback rule: on any mismatch, the only prefix reused is a single PAT0 match. No deeper overlap tracking is performed.
- `en`=0: state, `hit_cnt` and `last_q` hold; `hit`=0.
- `hit_cnt` saturates at 2^CNT_W−1. Once saturated, further detections still pulse `hit` but the count does not change.
- `last_q` updates to `q` on every enabled cycle.
- Reset values: state=IDLE, `hit`=0, `hit_cnt`=0, `last_q`=0.

## Timing
- Latency: `q` sampled at edge N while in GOT1 with q==PAT2 gives `hit`=1 during cycle N→N+1. It is cleared at edge N+1 unless a new detection occurs there.
- Back-to-back hits are only possible when PAT2==PAT0 and the PAT1/PAT2 pair follows immediately. Minimum hit spacing is 2 enabled cycles in that case and 3 otherwise.
- Reset has priority over `en`:
  - Reset asserted mid-sequence clears state, `hit` and `hit_cnt` at that edge.
  - A detection coincident with reset is dropped.
  - The first sample after deassertion is evaluated from IDLE.
- `en` may toggle on any cycle. Disabled cycles do not break a sequence in progress.
- `q` is assumed stable around posedge because it is a registered output of the upstream stage; no input synchronizer is included.

## Structure
- Shared package `q3_seq_pkg` holds:
  - the state enum `q3_state_t` (IDLE/GOT0/GOT1, 2 bits);
  - `Q3_W`=3, matching the upstream flip-flop width;
  - default pattern constants.
- One sub-module, `sat_counter` (params `WIDTH`; ports clk, rst_n, inc, cnt), implements `hit_cnt` and is reusable by other counters in the tree.
- The FSM, `hit` register and `last_q` live in the top module.

## Test plan
- Basic detection: reset, then `en`=1 with q=1,5,7 → `hit`=1 one cycle after the third sample; `hit_cnt`=1; `state_o` ends at 0.
- PAT0 repeats: q=1,1,5,7 → single hit; `state_o` sequence is 1,1,2,0.
- Broken sequence: q=1,5,1,5,7 → exactly one hit, on the fifth sample; q=1,5,3,7 → no hit, state returns to 0.
- Enable gating: q=1 (en=1), q=6 (en=0), q=5 (en=1), q=2 (en=0), q=7 (en=1) → hit on the last sample; `last_q`=7; `hit`=0 during the disabled cycles.
- Saturation with CNT_W=2: five consecutive 1,5,7 sequences → five `hit` pulses; `hit_cnt` reads 1,2,3,3,3.
- Reset mid-sequence: q=1,5, then `rst_n`=1 coincident with q=7 → no hit, `hit_cnt`=0, `state_o`=0. After release, q=7 alone → no hit.

Source files
------------

// File: rtl/q3_seq_pkg.sv
// Shared types and defaults for the 3-bit sample sequence detector.
package q3_seq_pkg;

  localparam int unsigned Q3_W = 3;

  localparam logic [Q3_W-1:0] Q3_PAT0 = 3'd1;
  localparam logic [Q3_W-1:0] Q3_PAT1 = 3'd5;
  localparam logic [Q3_W-1:0] Q3_PAT2 = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGot0 = 2'd1,
    StGot1 = 2'd2
  } q3_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + WIDTH'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/q3_seq_detector.sv
// Detects the ordered sample sequence PAT0, PAT1, PAT2 on the enabled q stream,
// pulsing hit for one cycle per detection and counting detections.
module q3_seq_detector
  import q3_seq_pkg::*;
#(
  parameter int unsigned    W     = Q3_W,
  parameter logic [W-1:0]   PAT0  = W'(Q3_PAT0),
  parameter logic [W-1:0]   PAT1  = W'(Q3_PAT1),
  parameter logic [W-1:0]   PAT2  = W'(Q3_PAT2),
  parameter int unsigned    CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [W-1:0]     q,
  output logic             hit,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [1:0]       state_o,
  output logic [W-1:0]     last_q
);

  q3_state_t    state_q;
  logic         hit_q;
  logic [W-1:0] last_sample_q;
  logic         detect;
  logic         state_bad;

  assign detect    = en && (state_q == StGot1) && (q == PAT2);
  assign state_bad = state_q[1] & state_q[0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q       <= StIdle;
      hit_q         <= 1'b0;
      last_sample_q <= '0;
    end else if (en) begin
      hit_q         <= detect;
      last_sample_q <= q;
      case (state_q)
        StIdle:  state_q <= (q == PAT0) ? StGot0 : StIdle;
        StGot0: begin
          if (q == PAT1) begin
            state_q <= StGot1;
          end else if (q == PAT0) begin
            state_q <= StGot0;
          end else begin
            state_q <= StIdle;
          end
        end
        // A hit restarts from GOT0 only when PAT2 doubles as PAT0, which is the
        // same test as the mismatch fallback, so one compare covers both.
        StGot1:  state_q <= (q == PAT0) ? StGot0 : StIdle;
        default: state_q <= StIdle;
      endcase
    end else begin
      hit_q <= 1'b0;
      if (state_bad) begin
        state_q <= StIdle;
      end
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (detect),
    .cnt   (hit_cnt)
  );

  assign hit     = hit_q;
  assign state_o = state_q;
  assign last_q  = last_sample_q;

endmodule

// File: tb/tb_q3_seq_detector.sv
// Scoreboard bench for q3_seq_detector: default 8-bit counter plus a 2-bit saturating copy.
module tb_q3_seq_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] q;

  logic       hit_a, hit_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;
  logic [1:0] st_a, st_b;
  logic [2:0] last_a, last_b;

  always #5 clk = ~clk;

  q3_seq_detector u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .q       (q),
    .hit     (hit_a),
    .hit_cnt (cnt_a),
    .state_o (st_a),
    .last_q  (last_a)
  );

  q3_seq_detector #(
    .CNT_W (2)
  ) u_dut_sat (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .q       (q),
    .hit     (hit_b),
    .hit_cnt (cnt_b),
    .state_o (st_b),
    .last_q  (last_b)
  );

  typedef struct {
    logic       hit;
    logic [1:0] st;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    logic [2:0] last;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Reference behaviour, written from the sequence rules.
  logic [1:0] m_st   = 2'd0;
  logic [7:0] m_cnt  = 8'd0;
  logic [1:0] m_cnt2 = 2'd0;
  logic [2:0] m_last = 3'd0;
  logic       m_hit  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [2:0] v);
    if (r) begin
      m_st = 2'd0; m_hit = 1'b0; m_cnt = 8'd0; m_cnt2 = 2'd0; m_last = 3'd0;
    end else if (e) begin
      m_last = v;
      m_hit  = (m_st == 2'd2) && (v == 3'd7);
      if (m_hit) begin
        if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
        if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
      end
      case (m_st)
        2'd0:    m_st = (v == 3'd1) ? 2'd1 : 2'd0;
        2'd1:    m_st = (v == 3'd5) ? 2'd2 : (v == 3'd1) ? 2'd1 : 2'd0;
        default: m_st = (v == 3'd1) ? 2'd1 : 2'd0;
      endcase
    end else begin
      m_hit = 1'b0;
    end
  endtask

  task automatic apply(input logic r, input logic e, input logic [2:0] v);
    exp_t x;
    rst_n = r; en = e; q = v;
    model_step(r, e, v);
    x.hit = m_hit; x.st = m_st; x.cnt = m_cnt; x.cnt2 = m_cnt2; x.last = m_last;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_val("hit",      hit_a,  x.hit);
    check_val("state",    st_a,   x.st);
    check_val("hit_cnt",  cnt_a,  x.cnt);
    check_val("last_q",   last_a, x.last);
    check_val("hit_sat",  hit_b,  x.hit);
    check_val("cnt_sat",  cnt_b,  x.cnt2);
  endtask

  task automatic seq3(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    apply(1'b0, 1'b1, a);
    apply(1'b0, 1'b1, b);
    apply(1'b0, 1'b1, c);
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; q = 3'd0;
    #2;
    apply(1'b1, 1'b0, 3'd0);
    apply(1'b1, 1'b1, 3'd3);
    check_val("reset_cnt", cnt_a, 0);

    // Basic detection.
    seq3(3'd1, 3'd5, 3'd7);
    check_val("basic_hit", hit_a, 1);
    check_val("basic_cnt", cnt_a, 1);
    check_val("basic_state", st_a, 0);
    apply(1'b0, 1'b1, 3'd0);
    check_val("basic_pulse_clear", hit_a, 0);

    // PAT0 repeats.
    apply(1'b0, 1'b1, 3'd1);
    check_val("rep_st0", st_a, 1);
    seq3(3'd1, 3'd5, 3'd7);
    check_val("rep_cnt", cnt_a, 2);

    // Broken sequences.
    seq3(3'd1, 3'd5, 3'd1);
    apply(1'b0, 1'b1, 3'd5);
    apply(1'b0, 1'b1, 3'd7);
    check_val("broken_hit", hit_a, 1);
    seq3(3'd1, 3'd5, 3'd3);
    apply(1'b0, 1'b1, 3'd7);
    check_val("broken_nohit", hit_a, 0);
    check_val("broken_state", st_a, 0);

    // Enable gating.
    apply(1'b0, 1'b1, 3'd1);
    apply(1'b0, 1'b0, 3'd6);
    apply(1'b0, 1'b1, 3'd5);
    apply(1'b0, 1'b0, 3'd2);
    check_val("gate_state_hold", st_a, 2);
    apply(1'b0, 1'b1, 3'd7);
    check_val("gate_hit", hit_a, 1);
    check_val("gate_last", last_a, 7);

    // Saturation of the 2-bit copy.
    apply(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 5; i++) begin
      seq3(3'd1, 3'd5, 3'd7);
    end
    check_val("sat_cnt2", cnt_b, 3);
    check_val("sat_cnt8", cnt_a, 5);

    // Reset mid-sequence drops a coincident detection.
    apply(1'b0, 1'b1, 3'd1);
    apply(1'b0, 1'b1, 3'd5);
    apply(1'b1, 1'b1, 3'd7);
    check_val("rst_hit", hit_a, 0);
    check_val("rst_cnt", cnt_a, 0);
    check_val("rst_state", st_a, 0);
    apply(1'b0, 1'b1, 3'd7);
    check_val("rst_after_hit", hit_a, 0);

    // Random traffic against the model.
    for (int i = 0; i < 200; i++) begin
      apply(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0),
            3'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
